memory_arbiter: RTL and testbench

Single-port RAM arbiter between the pipeline's fetch stage and memory stage. Accepts the instruction-fetch request and the data load/store request, serialises them onto the one RAM port, and returns the `ihit`/`dhit` pulses and load data that the hazard logic consumes to advance or stall the pipeline. Data requests take strict priority over instruction fetches.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/arb_watchdog.sv | 40 ++++
 rtl/memory_arbiter.sv | 120 ++++++++++++
 tb/tb_memory_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM status encoding and the arbiter FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DREQ = 2'd1,
        IREQ = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Outstanding-access cycle counter; expired is high in the TIMEOUT-th cycle after clearing.
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // next count: clear wins over increment
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CW{1'b0}};
        end else if (en) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter, data over fetch priority.
// Optional access watchdog: define MEMORY_ARBITER_WATCHDOG_EN.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    arb_state_t state_q;
    arb_state_t state_d;
    ramstate_t  rs_s;
    logic       wd_expired_s;

    assign rs_s = ramstate_t'(ramstate);

`ifdef MEMORY_ARBITER_WATCHDOG_EN
    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (CLK),
        .rst     (nRST),
        .clr     (state_q == IDLE),
        .en      ((state_q != IDLE) && !wd_expired_s),
        .expired (wd_expired_s)
    );
`else
    assign wd_expired_s = 1'b0;
`endif

    // next state, RAM port drive and hit/error pulses
    always_comb begin
        state_d  = state_q;
        ihit     = 1'b0;
        dhit     = 1'b0;
        err      = 1'b0;
        iload    = 32'h0000_0000;
        dload    = 32'h0000_0000;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0000_0000;
        ramstore = 32'h0000_0000;
        case (state_q)
            IDLE: begin
                if (dREN || dWEN) begin
                    state_d = DREQ;
                end else if (iREN) begin
                    state_d = IREQ;
                end else begin
                    state_d = IDLE;
                end
            end
            DREQ: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;
                // a flushed request is abandoned even if the RAM answers this cycle
                if (!(dREN || dWEN)) begin
                    state_d = IDLE;
                end else if ((rs_s == ERROR) || wd_expired_s) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else if (rs_s == ACCESS) begin
                    dhit    = 1'b1;
                    dload   = ramload;
                    state_d = IDLE;
                end else begin
                    state_d = DREQ;
                end
            end
            IREQ: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (!iREN) begin
                    state_d = IDLE;
                end else if ((rs_s == ERROR) || wd_expired_s) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else if (rs_s == ACCESS) begin
                    ihit    = 1'b1;
                    iload   = ramload;
                    state_d = IDLE;
                end else begin
                    state_d = IREQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state register; reset returns to IDLE at once so every output drops with it
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed table-driven bench for memory_arbiter plus reset and watchdog sequences.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int          TO = 8;
    localparam logic [31:0] IA = 32'h0000_0100;
    localparam logic [31:0] DA = 32'h0000_0200;
    localparam logic [31:0] DS = 32'hDEAD_BEEF;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        ihit, dhit, err, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    memory_arbiter #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ihit(ihit), .iload(iload), .dhit(dhit),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        iren, dren, dwen;
        logic [1:0]  rs;
        logic [31:0] rload;
        logic [132:0] exp;
    } vec_t;

    vec_t vecs[$];

    // g: 0 = RAM port idle, 1 = data side on the port, 2 = fetch side on the port
    function automatic vec_t mk(input logic iren, input logic dren, input logic dwen,
                                input logic [1:0] rs, input logic [31:0] rload, input int g,
                                input logic eih, input logic edh, input logic eer,
                                input logic eren, input logic ewen,
                                input logic [31:0] eil, input logic [31:0] edl);
        vec_t v;
        logic [31:0] a, s;
        a = (g == 1) ? DA : ((g == 2) ? IA : 32'h0);
        s = (g == 1) ? DS : 32'h0;
        v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs; v.rload = rload;
        v.exp = {eih, edh, eer, eren, ewen, a, s, eil, edl};
        return v;
    endfunction

    function automatic logic [132:0] outs();
        return {ihit, dhit, err, ramREN, ramWEN, ramaddr, ramstore, iload, dload};
    endfunction

    task automatic chk(input string nm, input logic [132:0] got, input logic [132:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic chk1(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    initial begin
        int errs;
        int hits;
        int errcyc;
        int ren_at [1:10];

        iaddr = IA; daddr = DA; dstore = DS;
        nRST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        ramstate = ACCESS; ramload = 32'h1111_1111;
        #3;
        chk("reset_state", outs(), 133'd0);
        @(negedge CLK);
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE; ramload = 32'h0;
        nRST = 1'b0;

        // fetch with ACCESS on the third driven cycle
        vecs.push_back(mk(1,0,0, FREE,   32'h0,         0, 0,0,0, 0,0, 32'h0, 32'h0));
        vecs.push_back(mk(1,0,0, BUSY,   32'h0,         2, 0,0,0, 1,0, 32'h0, 32'h0));
        vecs.push_back(mk(1,0,0, BUSY,   32'h0,         2, 0,0,0, 1,0, 32'h0, 32'h0));
        vecs.push_back(mk(1,0,0, ACCESS, 32'h2402_000A, 2, 1,0,0, 1,0, 32'h2402_000A, 32'h0));
        vecs.push_back(mk(0,0,0, FREE,   32'h0,         0, 0,0,0, 0,0, 32'h0, 32'h0));
        // fetch and store together: store first, one IDLE, then fetch
        vecs.push_back(mk(1,0,1, FREE,   32'h0,         0, 0,0,0, 0,0, 32'h0, 32'h0));
        vecs.push_back(mk(1,0,1, ACCESS, 32'h0000_0055, 1, 0,1,0, 0,1, 32'h0, 32'h0000_0055));
        vecs.push_back(mk(1,0,0, FREE,   32'h0,         0, 0,0,0, 0,0, 32'h0, 32'h0));
        vecs.push_back(mk(1,0,0, ACCESS, 32'h0000_1234, 2, 1,0,0, 1,0, 32'h0000_1234, 32'h0));
        vecs.push_back(mk(0,0,0, FREE,   32'h0,         0, 0,0,0, 0,0, 32'h0, 32'h0));
        // data read flushed while RAM busy; ACCESS in IDLE must not pulse
        vecs.push_back(mk(0,1,0, FREE,   32'h0,         0, 0,0,0, 0,0, 32'h0, 32'h0));
        vecs.push_back(mk(0,1,0, BUSY,   32'h0,         1, 0,0,0, 1,0, 32'h0, 32'h0));
        vecs.push_back(mk(0,0,0, BUSY,   32'h0,         1, 0,0,0, 0,0, 32'h0, 32'h0));
        vecs.push_back(mk(0,0,0, ACCESS, 32'hFFFF_FFFF, 0, 0,0,0, 0,0, 32'h0, 32'h0));
        // ERROR during fetch, then re-grant after one IDLE
        vecs.push_back(mk(1,0,0, FREE,   32'h0,         0, 0,0,0, 0,0, 32'h0, 32'h0));
        vecs.push_back(mk(1,0,0, ERROR,  32'h0000_0BAD, 2, 0,0,1, 1,0, 32'h0, 32'h0));
        vecs.push_back(mk(1,0,0, FREE,   32'h0,         0, 0,0,0, 0,0, 32'h0, 32'h0));
        vecs.push_back(mk(1,0,0, BUSY,   32'h0,         2, 0,0,0, 1,0, 32'h0, 32'h0));
        vecs.push_back(mk(1,0,0, ACCESS, 32'hA5A5_A5A5, 2, 1,0,0, 1,0, 32'hA5A5_A5A5, 32'h0));
        vecs.push_back(mk(0,0,0, FREE,   32'h0,         0, 0,0,0, 0,0, 32'h0, 32'h0));
        // data request during fetch waits; read+write together means write only
        vecs.push_back(mk(1,0,0, FREE,   32'h0,         0, 0,0,0, 0,0, 32'h0, 32'h0));
        vecs.push_back(mk(1,1,1, BUSY,   32'h0,         2, 0,0,0, 1,0, 32'h0, 32'h0));
        vecs.push_back(mk(1,1,1, ACCESS, 32'h0000_0077, 2, 1,0,0, 1,0, 32'h0000_0077, 32'h0));
        vecs.push_back(mk(0,1,1, FREE,   32'h0,         0, 0,0,0, 0,0, 32'h0, 32'h0));
        vecs.push_back(mk(0,1,1, ACCESS, 32'h0000_0099, 1, 0,1,0, 0,1, 32'h0, 32'h0000_0099));
        vecs.push_back(mk(0,0,0, FREE,   32'h0,         0, 0,0,0, 0,0, 32'h0, 32'h0));
        // minimum latency data read
        vecs.push_back(mk(0,1,0, FREE,   32'h0,         0, 0,0,0, 0,0, 32'h0, 32'h0));
        vecs.push_back(mk(0,1,0, ACCESS, 32'h0BAD_F00D, 1, 0,1,0, 1,0, 32'h0, 32'h0BAD_F00D));
        vecs.push_back(mk(0,0,0, FREE,   32'h0,         0, 0,0,0, 0,0, 32'h0, 32'h0));

        foreach (vecs[i]) begin
            @(posedge CLK); #1;
            iREN = vecs[i].iren; dREN = vecs[i].dren; dWEN = vecs[i].dwen;
            ramstate = vecs[i].rs; ramload = vecs[i].rload;
            @(negedge CLK);
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // stuck BUSY data read
        @(posedge CLK); #1;
        dREN = 1'b1; ramstate = BUSY;
        @(posedge CLK);
`ifdef MEMORY_ARBITER_WATCHDOG_EN
        errcyc = 0; hits = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            if (err && errcyc == 0) errcyc = c;
            if (dhit) hits++;
            ren_at[c] = int'(ramREN);
        end
        chk1("wd_err_cycle", errcyc, TO);
        chk1("wd_no_hit", hits, 0);
        chk1("wd_idle_after_err", ren_at[TO+1], 0);
        chk1("wd_regrant", ren_at[TO+2], 1);
`else
        errs = 0; hits = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge CLK);
            if (err) errs++;
            if (dhit) hits++;
        end
        chk1("nowd_no_err", errs, 0);
        chk1("nowd_no_hit", hits, 0);
        chk1("nowd_still_waiting", int'(ramREN), 1);
`endif
        @(posedge CLK); #1;
        dREN = 1'b0;
        @(negedge CLK);
        chk1("flush_strobe", int'(ramREN), 0);
        @(posedge CLK);

        // asynchronous reset mid-access
        @(posedge CLK); #1;
        dREN = 1'b1; ramstate = BUSY;
        @(posedge CLK);
        @(negedge CLK);
        chk1("pre_reset_dreq", int'(ramREN), 1);
        #2;
        ramstate = ACCESS; ramload = 32'h7777_7777;
        nRST = 1'b1;
        #1;
        chk("async_reset", outs(), 133'd0);
        dREN = 1'b0;
        @(posedge CLK); #3;
        nRST = 1'b0;
        hits = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            if (ihit || dhit || err || ramREN || ramWEN) hits++;
        end
        chk1("post_reset_quiet", hits, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
